// File: rtl/ram_cam_reader_pkg.sv
// ---------------------------------------------------------------------------
// cam_pkg
// Shared definitions for the camera frame-RAM reader: FSM state encoding,
// pixel/word geometry and the default frame length (160x120 4-bit pixels).
// ---------------------------------------------------------------------------
package cam_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam int PIX_W         = 4;
    localparam int WORD_PIX      = 8;
    localparam int WORD_W        = PIX_W * WORD_PIX;
    localparam int FRAME_LEN_DEF = 19200;

endpackage

// File: rtl/ram_cam_reader_if.sv
// ---------------------------------------------------------------------------
// ram_cam_reader_if
// Bundles the frame-RAM read port and the packed-word valid/ready stream.
//   ram_addr   : read address (reader -> RAM)
//   ram_data   : read nibble, one clk after ram_addr (RAM -> reader)
//   word_data  : 8 packed pixels, pixel 0 in bits [3:0] (reader -> consumer)
//   word_valid : word_data holds a word (reader -> consumer)
//   word_ready : consumer takes the word when word_valid && word_ready
// Modport master is the reader side, slave is the RAM/consumer side.
// ---------------------------------------------------------------------------
interface ram_cam_reader_if
    import cam_pkg::*;
#(
    parameter int ADDR_WIDTH = 15
);
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [PIX_W-1:0]      ram_data;
    logic [WORD_W-1:0]     word_data;
    logic                  word_valid;
    logic                  word_ready;

    modport master (
        output ram_addr,
        input  ram_data,
        output word_data,
        output word_valid,
        input  word_ready
    );

    modport slave (
        input  ram_addr,
        output ram_data,
        input  word_data,
        input  word_valid,
        output word_ready
    );
endinterface

// File: rtl/ram_cam_reader_packer.sv
// ---------------------------------------------------------------------------
// ram_cam_packer
// Collects nibbles little-nibble-first into a pack register and hands each
// completed word to a one-entry output register with a valid/ready handshake.
// Ports:
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   clear_i        : drop any partial word (frame start)
//   nib_vld_i/nib_i: incoming nibble
//   word_ready_i   : consumer ready
//   word_data_o    : output word, stable while not accepted
//   word_valid_o   : output word present
//   accept_o       : word transferred this cycle
//   stall_o        : upstream must not issue a new read this cycle
// ---------------------------------------------------------------------------
module ram_cam_packer
    import cam_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              nib_vld_i,
    input  logic [PIX_W-1:0]  nib_i,
    input  logic              word_ready_i,
    output logic [WORD_W-1:0] word_data_o,
    output logic              word_valid_o,
    output logic              accept_o,
    output logic              stall_o
);

    logic [WORD_W-1:0] pack_q, pack_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [WORD_W-1:0] out_q, out_d;
    logic              vld_q, vld_d;
    logic              out_free;
    logic [3:0]        fill;

    assign out_free = !vld_q || word_ready_i;
    assign accept_o = vld_q && word_ready_i;

    // A read issued now lands next cycle, so the nibble already in flight
    // counts toward "full": stop issuing once the pack register will hold
    // 8 nibbles and the output register cannot take them.
    assign fill    = cnt_q + {3'b000, nib_vld_i};
    assign stall_o = vld_q && !word_ready_i && (fill >= 4'd8);

    always_comb begin
        pack_d = pack_q;
        cnt_d  = cnt_q;
        out_d  = out_q;
        vld_d  = vld_q;
        if (accept_o) begin
            vld_d = 1'b0;
        end
        if (clear_i) begin
            cnt_d = 4'd0;
            vld_d = 1'b0;
        end else if (cnt_q == 4'd8) begin
            // Full word parked behind a busy output register.
            if (out_free) begin
                out_d = pack_q;
                vld_d = 1'b1;
                cnt_d = 4'd0;
                if (nib_vld_i) begin
                    pack_d[PIX_W-1:0] = nib_i;
                    cnt_d             = 4'd1;
                end
            end
        end else if (nib_vld_i) begin
            for (int i = 0; i < WORD_PIX; i++) begin
                if (cnt_q[2:0] == 3'(i)) begin
                    pack_d[i*PIX_W +: PIX_W] = nib_i;
                end
            end
            if (cnt_q == 4'd7 && out_free) begin
                out_d = pack_d;
                vld_d = 1'b1;
                cnt_d = 4'd0;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pack_q <= '0;
            cnt_q  <= 4'd0;
            out_q  <= '0;
            vld_q  <= 1'b0;
        end else begin
            pack_q <= pack_d;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            vld_q  <= vld_d;
        end
    end

    assign word_data_o  = out_q;
    assign word_valid_o = vld_q;

endmodule

// File: rtl/ram_cam_reader.sv
// ---------------------------------------------------------------------------
// ram_cam_reader
// Reads one frame of 4-bit pixels from a synchronous frame RAM (data one clk
// after address) and streams it as 32-bit words, pixel 0 in the low nibble.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   start      : pulse to read one frame (accepted only in IDLE)
//   busy       : frame in progress
//   done       : one-cycle pulse after the last word is accepted
//   checksum   : (RAM_CAM_READER_CHECKSUM_EN only) 16-bit sum of the upper
//                and lower halves of every accepted word, valid at done
//   bus        : ram_cam_reader_if.master (RAM read port + word stream)
// Build option: define RAM_CAM_READER_CHECKSUM_EN to add the checksum output.
// ---------------------------------------------------------------------------
module ram_cam_reader
    import cam_pkg::*;
#(
    parameter int FRAME_LEN  = FRAME_LEN_DEF,
    parameter int ADDR_WIDTH = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic busy,
    output logic done,
`ifdef RAM_CAM_READER_CHECKSUM_EN
    output logic [15:0] checksum,
`endif
    ram_cam_reader_if.master bus
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_LEN - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(FRAME_LEN / WORD_PIX - 1);

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] words_q;
    logic                  rd_vld_q;
    logic                  busy_q;
    logic                  done_q;

    logic start_acc;
    logic issue;
    logic stall;
    logic accept;

    // A start coinciding with the done pulse belongs to the finished frame.
    assign start_acc = (state_q == IDLE) && start && !done_q;
    assign issue     = (state_q == FETCH) && !stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            words_q  <= '0;
            rd_vld_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            rd_vld_q <= issue;
            if (accept) begin
                words_q <= words_q + 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (start_acc) begin
                        addr_q  <= '0;
                        words_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
                    if (issue) begin
                        if (addr_q == LAST_ADDR) begin
                            state_q <= FLUSH;
                        end else begin
                            addr_q <= addr_q + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    if (accept && words_q == LAST_WORD) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    ram_cam_packer u_packer (
        .clk_i        (clk),
        .rst_i        (reset),
        .clear_i      (start_acc),
        .nib_vld_i    (rd_vld_q),
        .nib_i        (bus.ram_data),
        .word_ready_i (bus.word_ready),
        .word_data_o  (bus.word_data),
        .word_valid_o (bus.word_valid),
        .accept_o     (accept),
        .stall_o      (stall)
    );

    assign bus.ram_addr = addr_q;
    assign busy         = busy_q;
    assign done         = done_q;

`ifdef RAM_CAM_READER_CHECKSUM_EN
    logic [15:0] sum_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q <= '0;
        end else if (start_acc) begin
            sum_q <= '0;
        end else if (accept) begin
            sum_q <= sum_q + bus.word_data[31:16] + bus.word_data[15:0];
        end
    end

    assign checksum = sum_q;
`endif

endmodule

// File: tb/tb_ram_cam_reader.sv
// ---------------------------------------------------------------------------
// tb_ram_cam_reader
// Directed bench for ram_cam_reader. dut uses FRAME_LEN=16, dut2 uses
// FRAME_LEN=64 for the random-backpressure run. RAM models return
// (addr mod 16), so words alternate 0x76543210 / 0xFEDCBA98.
// Inputs change on the falling edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_ram_cam_reader;
    import cam_pkg::*;

    logic clk    = 1'b0;
    logic reset  = 1'b1;
    logic start  = 1'b0;
    logic start2 = 1'b0;
    logic busy, done, busy2, done2;
`ifdef RAM_CAM_READER_CHECKSUM_EN
    logic [15:0] checksum, checksum2;
`endif
    int checks = 0;
    int errors = 0;

    ram_cam_reader_if #(.ADDR_WIDTH(15)) bus1 ();
    ram_cam_reader_if #(.ADDR_WIDTH(15)) bus2 ();

    ram_cam_reader #(.FRAME_LEN(16), .ADDR_WIDTH(15)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .busy  (busy),
        .done  (done),
`ifdef RAM_CAM_READER_CHECKSUM_EN
        .checksum (checksum),
`endif
        .bus   (bus1)
    );

    ram_cam_reader #(.FRAME_LEN(64), .ADDR_WIDTH(15)) dut2 (
        .clk   (clk),
        .reset (reset),
        .start (start2),
        .busy  (busy2),
        .done  (done2),
`ifdef RAM_CAM_READER_CHECKSUM_EN
        .checksum (checksum2),
`endif
        .bus   (bus2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        bus1.ram_data <= bus1.ram_addr[3:0];
        bus2.ram_data <= bus2.ram_addr[3:0];
    end

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({busy, done, bus1.word_valid} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl: busy/done/valid=%b required 000", {busy, done, bus1.word_valid});
        end
        checks++;
        if (bus1.word_data !== 32'h0 || bus1.ram_addr !== 15'd0) begin
            errors++;
            $display("FAIL reset_data: data=%h addr=%0d required 0/0", bus1.word_data, bus1.ram_addr);
        end
        reset = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (bus1.word_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: valid=%b busy=%b required 0/0", bus1.word_valid, busy);
        end
    endtask

    task automatic test_basic_frame(input string tag);
        int first_vld = -1;
        int done_at   = -1;
        int nwords    = 0;
        logic [31:0] w0 = 32'h0;
        logic [31:0] w1 = 32'h0;
        bus1.word_ready = 1'b1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (k > 0) @(negedge clk);
            if (k <= 15) begin
                checks++;
                if (bus1.ram_addr !== 15'(k)) begin
                    errors++;
                    $display("FAIL %s_addr k=%0d: got %0d required %0d", tag, k, bus1.ram_addr, k);
                end
            end
            if (bus1.word_valid === 1'b1 && first_vld < 0) first_vld = k;
            if (bus1.word_valid === 1'b1 && bus1.word_ready === 1'b1) begin
                if (nwords == 0) w0 = bus1.word_data;
                if (nwords == 1) w1 = bus1.word_data;
                nwords++;
            end
            if (done === 1'b1 && done_at < 0) done_at = k;
        end
        checks++;
        if (first_vld != 9) begin
            errors++;
            $display("FAIL %s_latency: first valid at %0d required 9", tag, first_vld);
        end
        checks++;
        if (nwords != 2 || w0 !== 32'h76543210 || w1 !== 32'hFEDCBA98) begin
            errors++;
            $display("FAIL %s_words: n=%0d w0=%h w1=%h required 2/76543210/fedcba98", tag, nwords, w0, w1);
        end
        checks++;
        if (done_at != 18 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_done: done at %0d busy=%b required 18/0", tag, done_at, busy);
        end
    endtask

    task automatic test_backpressure();
        int done_at = -1;
        int nwords  = 0;
        logic [31:0] w0 = 32'h0;
        logic [31:0] w1 = 32'h0;
        bus1.word_ready = 1'b1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int k = 0; k < 45; k++) begin
            if (k > 0) @(negedge clk);
            bus1.word_ready = !(k >= 9 && k < 29);
            if (k >= 9 && k < 29) begin
                checks++;
                if (bus1.word_valid !== 1'b1 || bus1.word_data !== 32'h76543210) begin
                    errors++;
                    $display("FAIL bp_hold k=%0d: valid=%b data=%h required 1/76543210", k, bus1.word_valid, bus1.word_data);
                end
            end
            if (k <= 28) begin
                checks++;
                if (bus1.ram_addr !== 15'((k < 15) ? k : 15)) begin
                    errors++;
                    $display("FAIL bp_addr k=%0d: got %0d required %0d", k, bus1.ram_addr, (k < 15) ? k : 15);
                end
            end
            if (bus1.word_valid === 1'b1 && bus1.word_ready === 1'b1) begin
                if (nwords == 0) w0 = bus1.word_data;
                if (nwords == 1) w1 = bus1.word_data;
                nwords++;
            end
            if (done === 1'b1 && done_at < 0) done_at = k;
        end
        checks++;
        if (nwords != 2 || w0 !== 32'h76543210 || w1 !== 32'hFEDCBA98) begin
            errors++;
            $display("FAIL bp_words: n=%0d w0=%h w1=%h required 2/76543210/fedcba98", nwords, w0, w1);
        end
        checks++;
        if (done_at != 31) begin
            errors++;
            $display("FAIL bp_done: done at %0d required 31", done_at);
        end
        bus1.word_ready = 1'b1;
    endtask

    task automatic test_restart();
        int nwords  = 0;
        int ndone   = 0;
        int done_at = -1;
        bus1.word_ready = 1'b1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (k > 0) @(negedge clk);
            if (bus1.word_valid === 1'b1 && bus1.word_ready === 1'b1) nwords++;
            if (done === 1'b1) begin
                ndone++;
                done_at = k;
            end
            start = (k == 5) || (done === 1'b1);
        end
        start = 1'b0;
        checks++;
        if (nwords != 2 || ndone != 1) begin
            errors++;
            $display("FAIL restart_count: words=%0d dones=%0d required 2/1", nwords, ndone);
        end
        checks++;
        if (done_at != 18) begin
            errors++;
            $display("FAIL restart_done: done at %0d required 18", done_at);
        end
        checks++;
        if (busy !== 1'b0 || bus1.word_valid !== 1'b0) begin
            errors++;
            $display("FAIL restart_idle: busy=%b valid=%b required 0/0", busy, bus1.word_valid);
        end
    endtask

    task automatic test_async_reset();
        int bad = 0;
        bus1.word_ready = 1'b1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (bus1.ram_addr !== 15'd5 || busy !== 1'b1) begin
            errors++;
            $display("FAIL areset_pre: addr=%0d busy=%b required 5/1", bus1.ram_addr, busy);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (bus1.ram_addr !== 15'd0 || bus1.word_data !== 32'h0 ||
            {bus1.word_valid, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL areset_now: addr=%0d data=%h valid/busy/done=%b required 0/0/000",
                     bus1.ram_addr, bus1.word_data, {bus1.word_valid, busy, done});
        end
        @(negedge clk) reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus1.word_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL areset_quiet: %0d cycles with activity required 0", bad);
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 40; f++) begin
            int widx = 0;
            bit seen_done = 1'b0;
            bit pend = 1'b0;
            logic [31:0] held = 32'h0;
            logic [31:0] exp_w;
            logic [15:0] sum = 16'h0;
            bus2.word_ready = 1'b0;
            @(negedge clk) start2 = 1'b1;
            @(negedge clk) start2 = 1'b0;
            for (int c = 0; c < 2000 && !seen_done; c++) begin
                if (c > 0) @(negedge clk);
                if (pend) begin
                    checks++;
                    if (bus2.word_valid !== 1'b1 || bus2.word_data !== held) begin
                        errors++;
                        $display("FAIL rnd_stable f=%0d: valid=%b data=%h required 1/%h", f, bus2.word_valid, bus2.word_data, held);
                    end
                end
                bus2.word_ready = 1'($urandom_range(0, 1));
                pend = 1'b0;
                if (bus2.word_valid === 1'b1 && bus2.word_ready === 1'b1) begin
                    exp_w = widx[0] ? 32'hFEDCBA98 : 32'h76543210;
                    checks++;
                    if (bus2.word_data !== exp_w) begin
                        errors++;
                        $display("FAIL rnd_word f=%0d w=%0d: got %h required %h", f, widx, bus2.word_data, exp_w);
                    end
                    sum = sum + exp_w[31:16] + exp_w[15:0];
                    widx++;
                end else if (bus2.word_valid === 1'b1) begin
                    pend = 1'b1;
                    held = bus2.word_data;
                end
                if (done2 === 1'b1) begin
                    seen_done = 1'b1;
                    checks++;
                    if (widx != 8) begin
                        errors++;
                        $display("FAIL rnd_count f=%0d: got %0d words required 8", f, widx);
                    end
`ifdef RAM_CAM_READER_CHECKSUM_EN
                    checks++;
                    if (checksum2 !== sum) begin
                        errors++;
                        $display("FAIL rnd_checksum f=%0d: got %h required %h", f, checksum2, sum);
                    end
`endif
                end
            end
            if (!seen_done) begin
                checks++;
                errors++;
                $display("FAIL rnd_timeout f=%0d: no done within 2000 cycles", f);
            end
        end
    endtask

    initial begin
        bus1.word_ready = 1'b1;
        bus2.word_ready = 1'b0;
        test_reset();
        test_basic_frame("basic");
        test_backpressure();
        test_restart();
        test_async_reset();
        test_basic_frame("post_reset");
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_cam_reader.md
RAM_CAM_READER -- requirements
Module: ram_cam_reader

Interface
REQ-001 Parameter FRAME_LEN, default 19200, SHALL set the number of 4-bit pixels per frame (160x120); it SHALL be a multiple of 8.
REQ-002 Parameter ADDR_WIDTH, default 15, SHALL set the width of the frame-RAM read address.
REQ-003 Port list:
  clk          input   1            single clock; all logic is rising-edge
  reset        input   1            asynchronous, active-high reset
  start        input   1            pulse: begin reading one frame
  busy         output  1            high from accepted start until done
  done         output  1            one-cycle pulse after the last word is accepted
  ram_addr     output  ADDR_WIDTH   frame-RAM read address
  ram_data     input   4            frame-RAM read data, valid one clk after ram_addr
  word_data    output  32           packed pixels
  word_valid   output  1            word_data holds a valid word
  word_ready   input   1            consumer accepts the word when word_valid && word_ready

Function
REQ-004 FSM states SHALL be IDLE, FETCH, FLUSH.
REQ-005 IDLE: start=1 SHALL clear the address and pack counters, set busy and enter FETCH on the next clk.
REQ-006 start while busy=1 SHALL be ignored.
REQ-007 FETCH: each cycle with no stall, ram_addr SHALL advance by 1, from 0 to FRAME_LEN-1.
REQ-008 Stall SHALL be the condition "pack register full and output register holding an unaccepted word"; while stalled, ram_addr SHALL hold and no nibble SHALL be lost or duplicated.
REQ-009 ram_data SHALL be sampled exactly one clk after its address was issued.
REQ-010 Packing SHALL be little-nibble-first: pixel n of a word goes to word_data[4n+3:4n], n=0..7.
REQ-011 When 8 nibbles are packed, the word SHALL move to the output register in the same cycle if that register is empty or being accepted.
REQ-012 Once the last address is issued, the FSM SHALL enter FLUSH and wait for the final nibble and word.
REQ-013 Leaving FLUSH: on acceptance of word FRAME_LEN/8-1, done SHALL pulse for 1 cycle, busy SHALL clear and the FSM SHALL return to IDLE.
REQ-014 word_data SHALL stay stable while word_valid=1 and word_ready=0.
REQ-015 With word_ready held at 1, throughput SHALL be one nibble per clk; the first word_valid SHALL occur 9 clks after start.
REQ-016 start and done in the same cycle SHALL not start a new frame; start is only accepted in IDLE.

Reset
REQ-017 reset SHALL force IDLE, ram_addr=0, word_data=0, word_valid=0, busy=0, done=0, and clear all counters immediately, including mid-frame.
REQ-018 After reset deasserts, no word SHALL be emitted until a new start.

Configuration
REQ-019 Macro RAM_CAM_READER_CHECKSUM_EN, when defined, SHALL add output checksum[15:0]:
  - Value: modulo-2^16 sum of the upper and lower halves of every accepted word in the frame.
  - Cleared on start and on reset.
  - Valid when done pulses.
REQ-020 Without RAM_CAM_READER_CHECKSUM_EN, the checksum port and its logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-021 A shared package cam_pkg SHALL hold:
  - the FSM state encoding (IDLE=0, FETCH=1, FLUSH=2);
  - the PIX_W=4 and WORD_PIX=8 constants;
  - the default FRAME_LEN.
REQ-022 Sub-module ram_cam_packer SHALL hold the nibble-to-word pack register and the one-entry output register with the valid/ready handshake; the FSM and address counter SHALL live in the top module.

Verification
REQ-023 Use FRAME_LEN=16 and a RAM model holding nibble value (addr mod 16). Pulse start with word_ready=1. Required: words 0x76543210 then 0xFEDCBA98; done pulses 1 clk after the second is accepted; ram_addr sweeps 0..15 with no gaps.
REQ-024 Backpressure: hold word_ready=0 for 20 clks after the first word_valid. Required: ram_addr freezes, and word 0x76543210 stays stable. Release word_ready; the remaining words arrive correct, with no lost or duplicate nibbles.
REQ-025 Pulse start again in mid-frame and in the done cycle. Required: no restart, and exactly FRAME_LEN/8 words per frame.
REQ-026 Assert reset asynchronously in mid-FETCH at addr 5. Required: all outputs are 0 immediately. A following start produces a full, correct frame from addr 0.
REQ-027 Randomly toggle word_ready (50%) over 100 frames of FRAME_LEN=19200. Required: every word matches the model. With the checksum enabled, checksum equals the reference sum at done.
